// File: rtl/serial_nibble_comparator_if.sv
// serial_nibble_comparator_if: start/operand request and status/result bundle
interface serial_nibble_comparator_if #(parameter int WIDTH = 4);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             Equal;
   logic             Asmaller;
   logic             Agreater;
   modport master (output start, A, B, input busy, done, Equal, Asmaller, Agreater);
   modport slave  (input start, A, B, output busy, done, Equal, Asmaller, Agreater);
endinterface

// File: rtl/serial_nibble_comparator.sv
// serial_nibble_comparator: MSB-first bit-serial unsigned magnitude compare with early exit
module serial_nibble_comparator #(
   parameter int WIDTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   serial_nibble_comparator_if.slave   s
);
   localparam int IDX_W = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [IDX_W-1:0] r_idx;
   logic             r_eq;
   logic             r_lt;
   logic             r_gt;
   logic             w_a_bit;
   logic             w_b_bit;
   logic             w_last;
   assign w_a_bit = r_a[r_idx];
   assign w_b_bit = r_b[r_idx];
   assign w_last  = (w_a_bit != w_b_bit) || (r_idx == '0);
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   // next state and status decode; a differing bit or the last bit ends the compare
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE)    ? (s.start ? COMPARE : IDLE) :
               (r_state == COMPARE) ? (w_last ? DONE : COMPARE) : IDLE;
   end
   assign s.busy     = (r_state == COMPARE);
   assign s.done     = (r_state == DONE);
   assign s.Equal    = r_eq;
   assign s.Asmaller = r_lt;
   assign s.Agreater = r_gt;
   // operand capture, bit index walk and result flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a   <= '0;
         r_b   <= '0;
         r_idx <= '0;
         r_eq  <= 1'b0;
         r_lt  <= 1'b0;
         r_gt  <= 1'b0;
      end else if (r_state == IDLE && s.start) begin
         r_a   <= s.A;
         r_b   <= s.B;
         r_idx <= IDX_W'(WIDTH - 1);
         r_eq  <= 1'b0;
         r_lt  <= 1'b0;
         r_gt  <= 1'b0;
      end else if (r_state == COMPARE) begin
         if (w_a_bit & ~w_b_bit)      r_gt  <= 1'b1;
         else if (~w_a_bit & w_b_bit) r_lt  <= 1'b1;
         else if (r_idx == '0)        r_eq  <= 1'b1;
         else                         r_idx <= r_idx - 1'b1;
      end
   end
endmodule

// File: doc/serial_nibble_comparator.md
SERIAL_NIBBLE_COMPARATOR -- requirements
Module: serial_nibble_comparator

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  request to begin a comparison; sampled only in IDLE.
REQ-006 Port: A  input  WIDTH  operand A (unsigned); captured on the edge that accepts start.
REQ-007 Port: B  input  WIDTH  operand B (unsigned); captured on the edge that accepts start.
REQ-008 Port: busy  output  1  high while the FSM is in COMPARE.
REQ-009 Port: done  output  1  one-cycle pulse; result valid from this cycle onward.
REQ-010 Port: Equal  output  1  registered result A==B.
REQ-011 Port: Asmaller  output  1  registered result A<B.
REQ-012 Port: Agreater  output  1  registered result A>B.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, COMPARE, DONE.
REQ-014 IDLE with start=1 at a rising edge SHALL load a_reg=A, b_reg=B, idx=WIDTH-1, clear Equal/Asmaller/Agreater to 0, and enter COMPARE.
REQ-015 IDLE with start=0 SHALL remain in IDLE with all registers unchanged.
REQ-016 Each COMPARE edge SHALL examine bit a_reg[idx] vs b_reg[idx], MSB first, one bit per cycle, using the 1-bit rule: Agreater=a&~b, Asmaller=~a&b, equal=~(Agreater|Asmaller).
REQ-017 In COMPARE, if a_reg[idx]=1 and b_reg[idx]=0, the block SHALL set Agreater=1 and enter DONE (early termination).
REQ-018 In COMPARE, if a_reg[idx]=0 and b_reg[idx]=1, the block SHALL set Asmaller=1 and enter DONE (early termination).
REQ-019 In COMPARE, if the bits are equal and idx>0, the block SHALL decrement idx and stay in COMPARE.
REQ-020 In COMPARE, if the bits are equal and idx=0, the block SHALL set Equal=1 and enter DONE.
REQ-021 DONE SHALL last exactly one cycle, assert done=1 for that cycle, then return to IDLE unconditionally.
REQ-022 done SHALL rise N clock edges after the start-accepting edge, where N is the number of bits examined (1..WIDTH); worst case WIDTH edges (A==B).
REQ-023 busy SHALL be 1 exactly in COMPARE; done SHALL be 1 exactly in DONE; busy and done SHALL never both be 1.
REQ-024 After done, exactly one of Equal/Asmaller/Agreater SHALL be 1, and all three SHALL hold their values through IDLE until the next accepted start.
REQ-025 start asserted in COMPARE or DONE SHALL be ignored (not queued); A/B changes after capture SHALL not affect the result in progress.
REQ-026 start held high continuously SHALL cause a new comparison to be accepted on the first IDLE edge after each DONE (back-to-back spacing N+2 edges).
REQ-027 idx SHALL be ceil(log2(WIDTH)) bits wide and SHALL never underflow.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state=IDLE, busy=0, done=0, Equal=0, Asmaller=0, Agreater=0, a_reg=0, b_reg=0, idx=0.
REQ-029 rst asserted mid-COMPARE SHALL abort the comparison with no done pulse; the first edge after rst release SHALL be treated as IDLE.
REQ-030 start asserted on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-031 Reset: assert rst mid-cycle -> all outputs 0 asynchronously; release, no start -> outputs stay 0 indefinitely.
REQ-032 MSB decides: A=4'b1000, B=4'b0111, start one cycle -> done 1 edge after acceptance, Agreater=1, Equal=0, Asmaller=0, busy high 1 cycle.
REQ-033 LSB decides: A=4'b0110, B=4'b0111 -> done 4 edges after acceptance, Asmaller=1; Equal: A=B=4'b1010 -> done 4 edges after, Equal=1.
REQ-034 Ignore/hold: during COMPARE of A=5,B=3 pulse start and change A=0,B=15 -> result Agreater=1, single done pulse; flags held until next start, then cleared to 0 on acceptance.
REQ-035 Abort: A=B=4'b1111, assert rst 2 edges after acceptance -> no done pulse, all flags 0; next start with A=2,B=9 -> Asmaller=1.
REQ-036 Exhaustive: all 256 (A,B) pairs with start held high -> each result matches unsigned compare, done count=256, latency per REQ-022.
